// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the fetch-side PC sequencer.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    WAIT_PRESS = 2'd1,
    WAIT_REL   = 2'd2,
    COMMIT     = 2'd3
  } state_t;

  localparam int         PC_STEP  = 4;
  localparam logic [5:0] JR_FUNCT = 6'b001000;

endpackage

// File: rtl/pc_sequencer_if.sv
// Decode-to-sequencer bundle: control decodes and operands in, PC/commit status out.
interface pc_sequencer_if #(
  parameter int PC_W = 32
);
  logic            branch;
  logic            branch_ne;
  logic            alu_zero;
  logic            jump;
  logic            jal;
  logic            jr;
  logic            pause;
  logic            in_req;
  logic [15:0]     imm16;
  logic [25:0]     target26;
  logic [PC_W-1:0] rs_data;
  logic            btn_confirm;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] link_addr;
  logic            instr_valid;
  logic            waiting;

  modport master (
    output branch, branch_ne, alu_zero, jump, jal, jr, pause, in_req,
    output imm16, target26, rs_data, btn_confirm,
    input  pc, link_addr, instr_valid, waiting
  );

  modport slave (
    input  branch, branch_ne, alu_zero, jump, jal, jr, pause, in_req,
    input  imm16, target26, rs_data, btn_confirm,
    output pc, link_addr, instr_valid, waiting
  );
endinterface

// File: rtl/pc_sequencer_btn_debounce.sv
// Operator button conditioning: 2-flop synchroniser, stability counter, rising-edge pulse.
module btn_debounce #(
  parameter int DEBOUNCE_N = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level,
  output logic rise
);
  localparam int CNT_W = $clog2(DEBOUNCE_N + 1);

  logic [1:0]       sync_reg;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             level_reg, level_next;
  logic             rise_reg, rise_next;

  // Level flips only after DEBOUNCE_N consecutive samples disagreeing with it.
  always_comb begin
    cnt_next   = cnt_reg;
    level_next = level_reg;
    rise_next  = 1'b0;
    if (sync_reg[1] == level_reg) begin
      cnt_next = '0;
    end else if (cnt_reg == CNT_W'(DEBOUNCE_N - 1)) begin
      cnt_next   = '0;
      level_next = sync_reg[1];
      rise_next  = sync_reg[1];
    end else begin
      cnt_next = cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg  <= '0;
      cnt_reg   <= '0;
      level_reg <= 1'b0;
      rise_reg  <= 1'b0;
    end else begin
      sync_reg  <= {sync_reg[0], btn};
      cnt_reg   <= cnt_next;
      level_reg <= level_next;
      rise_reg  <= rise_next;
    end
  end

  assign level = level_reg;
  assign rise  = rise_reg;
endmodule

// File: rtl/pc_sequencer.sv
// Program-counter stage: next-PC select, jal link address, operator stall for pause/input.
// Optional PC_PAUSE_TIMEOUT_EN lets a pause resume on its own after TIMEOUT_N cycles.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int              PC_W       = 32,
  parameter logic [PC_W-1:0] RESET_PC   = '0,
  parameter int              DEBOUNCE_N = 250000,
  parameter int              TIMEOUT_N  = 50000000
) (
  input logic           clk,
  input logic           rst_n,
  pc_sequencer_if.slave bus
);
  state_t          state_reg, state_next;
  logic [PC_W-1:0] pc_reg, pc_next;
  logic            waiting_reg, waiting_next;
  logic [PC_W-1:0] pc4, br_target, jmp_target, seq_target;
  logic            stall_req, btn_level, btn_rise, timeout_hit;

  if (DEBOUNCE_N < 2 || TIMEOUT_N < 2) begin : g_param_check
    $error("pc_sequencer: DEBOUNCE_N and TIMEOUT_N must be at least 2");
  end

  btn_debounce #(
    .DEBOUNCE_N(DEBOUNCE_N)
  ) u_btn (
    .clk  (clk),
    .rst_n(rst_n),
    .btn  (bus.btn_confirm),
    .level(btn_level),
    .rise (btn_rise)
  );

  assign pc4        = pc_reg + PC_W'(PC_STEP);
  assign br_target  = pc4 + {{(PC_W-18){bus.imm16[15]}}, bus.imm16, 2'b00};
  assign jmp_target = {pc4[PC_W-1:28], bus.target26, 2'b00};
  assign stall_req  = bus.pause | bus.in_req;

  always_comb begin
    seq_target = pc4;
    if (bus.jump | bus.jal)
      seq_target = jmp_target;
    else if (bus.jr)
      seq_target = bus.rs_data;
    else if (bus.branch & (bus.alu_zero ^ bus.branch_ne))
      seq_target = br_target;
  end

`ifdef PC_PAUSE_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_N + 1);
  logic [TO_W-1:0] to_cnt_reg;
  logic            pause_wait_reg;

  // Only a pause stall may time out; an input instruction always needs the operator.
  assign timeout_hit = (state_reg == WAIT_PRESS) && pause_wait_reg &&
                       (to_cnt_reg == TO_W'(TIMEOUT_N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_reg     <= '0;
      pause_wait_reg <= 1'b0;
    end else begin
      if (state_reg != WAIT_PRESS)
        to_cnt_reg <= '0;
      else if (!timeout_hit)
        to_cnt_reg <= to_cnt_reg + TO_W'(1);
      if (state_reg == RUN && state_next == WAIT_PRESS)
        pause_wait_reg <= bus.pause & ~bus.in_req;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    unique case (state_reg)
      RUN: begin
        if (stall_req)
          state_next = WAIT_PRESS;
        else
          pc_next = seq_target;
      end
      WAIT_PRESS: begin
        // Edge, not level: a button already held on entry must be released first.
        if (btn_rise)
          state_next = WAIT_REL;
        else if (timeout_hit)
          state_next = COMMIT;
      end
      WAIT_REL: begin
        if (!btn_level)
          state_next = COMMIT;
      end
      COMMIT: begin
        pc_next    = pc4;
        state_next = RUN;
      end
      default: state_next = RUN;
    endcase
    waiting_next = (state_next == WAIT_PRESS) || (state_next == WAIT_REL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= RUN;
      pc_reg      <= RESET_PC;
      waiting_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      waiting_reg <= waiting_next;
    end
  end

  assign bus.pc          = pc_reg;
  assign bus.link_addr   = pc4;
  assign bus.waiting     = waiting_reg;
  assign bus.instr_valid = (state_reg == COMMIT) || ((state_reg == RUN) && !stall_req);
endmodule
